// File: rtl/mod_exp_pkg.sv
// ============================================================================
// Module      : mod_exp_pkg
// Description : Shared constants, state encoding and helpers for mod_exp_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_exp_pkg;

    localparam int W_DEF = 260;

    // Controller states
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_CHECK     = 3'd2;
    localparam logic [2:0] S_ISSUE_MUL = 3'd3;
    localparam logic [2:0] S_ISSUE_SQ  = 3'd4;
    localparam logic [2:0] S_WAIT_ACK  = 3'd5;
    localparam logic [2:0] S_WAIT_DONE = 3'd6;
    localparam logic [2:0] S_FIN       = 3'd7;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_SQ  = 1'b1
    } op_kind_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
// ============================================================================
// Module      : mod_exp_ctrl
// Description : Right-to-left binary modular exponentiation controller that
//               drives an external mulmod engine over a start/done handshake.
//               Optional MODEXP_MULCNT_EN adds a saturating request counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_exp_ctrl
    import mod_exp_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [W-1:0] base_i,
    input  logic [W-1:0] exp_i,
    input  logic [W-1:0] m_i,
    output logic [W-1:0] result_o,
    output logic         done_o,
    output logic         err_o,
    output logic         mm_start_o,
    output logic [W-1:0] mm_a_o,
    output logic [W-1:0] mm_b_o,
    output logic [W-1:0] mm_m_o,
    input  logic [W-1:0] mm_result_i,
`ifdef MODEXP_MULCNT_EN
    output logic [15:0]  mul_count_o,
`endif
    input  logic         mm_done_i
);

    localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [2:0]   state_q,    state_d;
    logic [W-1:0] x_q,        x_d;
    logic [W-1:0] e_q,        e_d;
    logic [W-1:0] r_q,        r_d;
    logic [W-1:0] mod_q,      mod_d;
    op_kind_e     op_q,       op_d;
    logic [W-1:0] result_q,   result_d;
    logic         done_q,     done_d;
    logic         err_q,      err_d;
    logic         mm_start_q, mm_start_d;
    logic [W-1:0] mm_a_q,     mm_a_d;
    logic [W-1:0] mm_b_q,     mm_b_d;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        e_d        = e_q;
        r_d        = r_q;
        mod_d      = mod_q;
        op_d       = op_q;
        result_d   = result_q;
        done_d     = done_q;
        err_d      = err_q;
        mm_start_d = 1'b0;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;

        case (state_q)
            S_IDLE: begin
                done_d = ~start_i;
                if (start_i) begin
                    state_d = S_LOAD;
                    err_d   = 1'b0;
                end
            end

            S_LOAD: begin
                x_d   = base_i;
                e_d   = exp_i;
                mod_d = m_i;
                r_d   = C_ONE;
                if ((m_i == '0) || (base_i >= m_i)) begin
                    err_d   = 1'b1;
                    r_d     = '0;
                    state_d = S_FIN;
                end else if (m_i == C_ONE) begin
                    r_d     = '0;
                    state_d = S_FIN;
                end else begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (e_q == '0) begin
                    state_d = S_FIN;
                end else if (e_q[0]) begin
                    mm_a_d     = r_q;
                    mm_b_d     = x_q;
                    op_d       = OP_MUL;
                    mm_start_d = 1'b1;
                    state_d    = S_ISSUE_MUL;
                end else begin
                    mm_a_d     = x_q;
                    mm_b_d     = x_q;
                    op_d       = OP_SQ;
                    mm_start_d = 1'b1;
                    state_d    = S_ISSUE_SQ;
                end
            end

            // The request pulse is registered on entry, so it is visible for
            // exactly the one cycle spent in ISSUE_*.
            S_ISSUE_MUL, S_ISSUE_SQ: begin
                state_d = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                if (!mm_done_i) begin
                    state_d = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                if (mm_done_i) begin
                    if (op_q == OP_MUL) begin
                        r_d = mm_result_i;
                        if (e_q > C_ONE) begin
                            mm_a_d     = x_q;
                            mm_b_d     = x_q;
                            op_d       = OP_SQ;
                            mm_start_d = 1'b1;
                            state_d    = S_ISSUE_SQ;
                        end else begin
                            // Top exponent bit consumed: the final square is skipped.
                            e_d     = '0;
                            state_d = S_CHECK;
                        end
                    end else begin
                        x_d     = mm_result_i;
                        e_d     = e_q >> 1;
                        state_d = S_CHECK;
                    end
                end
            end

            S_FIN: begin
                result_d = r_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            e_q        <= '0;
            r_q        <= '0;
            mod_q      <= '0;
            op_q       <= OP_MUL;
            result_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            e_q        <= e_d;
            r_q        <= r_d;
            mod_q      <= mod_d;
            op_q       <= op_d;
            result_q   <= result_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mm_start_q <= mm_start_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
        end
    end

`ifdef MODEXP_MULCNT_EN
    logic [15:0] mul_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_count_q <= 16'd0;
        end else if ((state_q == S_IDLE) && start_i) begin
            mul_count_q <= 16'd0;
        end else if (mm_start_d) begin
            mul_count_q <= sat_inc16(mul_count_q);
        end
    end

    assign mul_count_o = mul_count_q;
`endif

    assign result_o   = result_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign mm_start_o = mm_start_q;
    assign mm_a_o     = mm_a_q;
    assign mm_b_o     = mm_b_q;
    // The latched modulus only changes in LOAD, so it is stable for every request.
    assign mm_m_o     = mod_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
// ============================================================================
// Module      : tb_mod_exp_ctrl
// Description : Self-checking bench for mod_exp_ctrl with a behavioural
//               mulmod engine and a left-to-right exponentiation reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_exp_ctrl;
    import mod_exp_pkg::*;

    localparam int W     = 260;
    localparam int LIMIT = 20000;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_i;
    logic [W-1:0] base_i, exp_i, m_i;
    logic [W-1:0] result_o;
    logic         done_o, err_o, mm_start_o;
    logic [W-1:0] mm_a_o, mm_b_o, mm_m_o;
    logic [W-1:0] mm_result_i;
    logic         mm_done_i;
`ifdef MODEXP_MULCNT_EN
    logic [15:0]  mul_count_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    mod_exp_ctrl #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .base_i      (base_i),
        .exp_i       (exp_i),
        .m_i         (m_i),
        .result_o    (result_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .mm_start_o  (mm_start_o),
        .mm_a_o      (mm_a_o),
        .mm_b_o      (mm_b_o),
        .mm_m_o      (mm_m_o),
        .mm_result_i (mm_result_i),
`ifdef MODEXP_MULCNT_EN
        .mul_count_o (mul_count_o),
`endif
        .mm_done_i   (mm_done_i)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, m};
        return p[W-1:0];
    endfunction

    // Left-to-right square-and-multiply: a different route to the same value.
    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                                input logic [W-1:0] m);
        logic [W-1:0] acc;
        acc = 1;
        for (int i = W - 1; i >= 0; i--) begin
            acc = mulmod(acc, acc, m);
            if (e[i]) acc = mulmod(acc, b, m);
        end
        return acc;
    endfunction

    // One multiply per set bit plus one square per bit below the top set bit.
    function automatic int ref_requests(input logic [W-1:0] e);
        int pc = 0;
        int hi = 0;
        for (int i = 0; i < W; i++) begin
            if (e[i]) begin
                pc++;
                hi = i;
            end
        end
        return pc + hi;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v = '0;
        for (int i = 0; i < 9; i++) v = (v << 32) | W'($urandom());
        return v;
    endfunction

    // Behavioural mulmod engine with random service time.
    initial begin : engine
        logic [W-1:0] la, lb, lm;
        logic stable, busy, was_busy;
        int lat;
        busy = 1'b0; stable = 1'b1; lat = 0;
        la = '0; lb = '0; lm = '0;
        mm_done_i   = 1'b1;
        mm_result_i = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy      = 1'b0;
                mm_done_i = 1'b1;
            end else begin
                was_busy = busy;
                if (busy) begin
                    if ({mm_a_o, mm_b_o, mm_m_o} !== {la, lb, lm}) stable = 1'b0;
                    lat--;
                    if (lat == 0) begin
                        check("operands_stable", W'(stable), W'(1));
                        mm_result_i = mulmod(la, lb, lm);
                        mm_done_i   = 1'b1;
                        busy        = 1'b0;
                    end
                end
                if (mm_start_o) begin
                    pulse_cnt++;
                    check("no_overlap", W'(was_busy), W'(0));
                    if (!was_busy) begin
                        la = mm_a_o; lb = mm_b_o; lm = mm_m_o;
                        busy = 1'b1; stable = 1'b1;
                        lat = $urandom_range(2, 5);
                        mm_done_i = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (done_o !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= LIMIT) check({tag, "_timeout"}, W'(1), W'(0));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] b, input logic [W-1:0] e,
                          input logic [W-1:0] m, output logic [W-1:0] res);
        logic [W-1:0] exp_res;
        logic         exp_err;
        int           exp_req;
        if (m == '0 || b >= m) begin
            exp_res = '0; exp_err = 1'b1; exp_req = 0;
        end else if (m == 1) begin
            exp_res = '0; exp_err = 1'b0; exp_req = 0;
        end else begin
            exp_res = ref_modexp(b, e, m); exp_err = 1'b0; exp_req = ref_requests(e);
        end
        wait_done({tag, "_idle"});
        pulse_cnt = 0;
        start_i = 1'b1; base_i = b; exp_i = e; m_i = m;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(tag);
        res = result_o;
        check({tag, "_result"}, result_o, exp_res);
        check({tag, "_err"}, W'(err_o), W'(exp_err));
        check({tag, "_requests"}, W'(pulse_cnt), W'(exp_req));
`ifdef MODEXP_MULCNT_EN
        check({tag, "_mul_count"}, W'(mul_count_o), W'(exp_req));
`endif
    endtask

    initial begin : main
        logic [W-1:0] res, b, e, m, big;
        int cyc;
        reset = 1'b1; start_i = 1'b0; base_i = '0; exp_i = '0; m_i = '0;
        repeat (3) @(negedge clk);
        check("rst_done", W'(done_o), W'(0));
        check("rst_result", result_o, '0);
        check("rst_err", W'(err_o), W'(0));
        check("rst_mm_start", W'(mm_start_o), W'(0));
        check("rst_mm_ops", mm_a_o | mm_b_o | mm_m_o, '0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_done", W'(done_o), W'(1));

        run_op("p3e5m7", 3, 5, 7, res);
        check("p3e5m7_const", res, 5);
        run_op("p2e10m1000", 2, 10, 1000, res);
        check("p2e10m1000_const", res, 24);
        run_op("exp0", 4, 0, 7, res);
        check("exp0_const", res, 1);
        run_op("m1", 0, 9, 1, res);
        run_op("m0", 3, 5, 0, res);
        run_op("base_ge_m", 9, 5, 7, res);

        big = '0; big[259] = 1'b1;
        m = big | W'(1);
        run_op("wide", 2, 259, m, res);
        check("wide_const", res, big);

        for (int i = 0; i < 6; i++) begin
            m = (i < 3) ? W'($urandom_range(2, 1000)) : rand_w();
            if (m < 2) m = 3;
            b = rand_w() % m;
            e = W'($urandom_range(1, 65535));
            run_op("rand", b, e, m, res);
        end
        m = rand_w() | W'(1);
        run_op("rand_fullexp", rand_w() % m, rand_w(), m, res);

        // Reset while the engine is working on a request
        wait_done("mid_idle");
        start_i = 1'b1; base_i = 5; exp_i = 16'hBEEF; m_i = 1009;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0;
        while (dut.state_q !== S_WAIT_DONE && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reach_wait", W'(dut.state_q), W'(S_WAIT_DONE));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_done", W'(done_o), W'(0));
        check("mid_rst_mm_start", W'(mm_start_o), W'(0));
        check("mid_rst_state", W'(dut.state_q), W'(S_IDLE));
        reset = 1'b0;
        @(negedge clk);
        run_op("after_rst", 6, 77, 101, res);

        // Start held high across completion: back-to-back single operations
        wait_done("held_idle");
        pulse_cnt = 0;
        start_i = 1'b1; base_i = 3; exp_i = 13; m_i = 11;
        @(negedge clk);
        wait_done("held_op1");
        check("held_op1_result", result_o, ref_modexp(3, 13, 11));
        @(negedge clk);
        wait_done("held_op2");
        start_i = 1'b0;
        check("held_op2_result", result_o, ref_modexp(3, 13, 11));
        check("held_requests", W'(pulse_cnt), W'(2 * ref_requests(13)));
        @(negedge clk);
        @(negedge clk);
        check("held_stop_done", W'(done_o), W'(1));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
